sram_burst_initiator: RTL and testbench

Initiator-side controller for the single-port OpenRAM SRAM macros (RW port: clk0/csb0/web0/addr0/din0/dout0) used for layer weight/bias storage. It converts a burst command plus a valid/ready write-data stream into SRAM write cycles. It converts read bursts into SRAM read cycles and returns the read words on a valid/ready response stream through a small credit-controlled buffer. It sits between the layer sequencer and one `*_sram_<words>_<width>_sky130A` instance, sharing its clock.

---
 rtl/sram_init_pkg.sv | 14 +
 rtl/sram_rsp_fifo.sv | 57 +++++
 rtl/sram_burst_initiator.sv | 128 ++++++++++++
 tb/tb_sram_burst_initiator.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_init_pkg.sv
// rtl/sram_init_pkg.sv - shared types and default sizes for the SRAM burst initiator
package sram_init_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } state_t;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_ADDR_WIDTH = 4;
    localparam int DEF_RSP_DEPTH  = 4;

endpackage

// File: rtl/sram_rsp_fifo.sv
// rtl/sram_rsp_fifo.sv - small response buffer holding SRAM read words until the consumer takes them
module sram_rsp_fifo #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic [DATA_WIDTH-1:0]   push_data,
    input  logic                    pop,
    output logic [DATA_WIDTH-1:0]   pop_data,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign empty    = (count == '0);
    assign full     = (count == (PTR_W + 1)'(DEPTH));
    assign do_pop   = pop && !empty;
    // A push into a full buffer is fine when the head leaves in the same cycle.
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    // Storage, pointers and occupancy; entries are cleared so the head reads zero after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + (PTR_W + 1)'(1);
            end else if (!do_push && do_pop) begin
                count <= count - (PTR_W + 1)'(1);
            end
        end
    end

endmodule

// File: rtl/sram_burst_initiator.sv
// rtl/sram_burst_initiator.sv - turns burst commands into OpenRAM RW-port cycles with a credited read return path
module sram_burst_initiator
    import sram_init_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int RSP_DEPTH  = DEF_RSP_DEPTH
) (
    input  logic                  clk0,
    input  logic                  rst0,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [ADDR_WIDTH-1:0] cmd_len,
    input  logic                  wdata_valid,
    output logic                  wdata_ready,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  rdata_valid,
    input  logic                  rdata_ready,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  busy,
    output logic                  csb0,
    output logic                  web0,
    output logic [ADDR_WIDTH-1:0] addr0,
    output logic [DATA_WIDTH-1:0] din0,
    input  logic [DATA_WIDTH-1:0] dout0
);

    localparam int CNT_W = $clog2(RSP_DEPTH) + 1;

    state_t                state;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [ADDR_WIDTH-1:0] beats;
    logic                  rd_stage1;
    logic                  rd_stage2;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [CNT_W-1:0]      fifo_count;
    logic [CNT_W:0]        used;
    logic                  has_credit;

    // Buffer slots already spoken for: words held plus reads still travelling through the SRAM.
    assign used       = (CNT_W + 1)'(fifo_count) + (CNT_W + 1)'(rd_stage1) + (CNT_W + 1)'(rd_stage2);
    assign has_credit = (state == READ) && !fifo_full && (used < (CNT_W + 1)'(RSP_DEPTH));

    assign cmd_ready   = (state == IDLE);
    assign wdata_ready = (state == WRITE);
    assign rdata_valid = !fifo_empty;
    assign busy        = (state != IDLE) || rd_stage1 || rd_stage2 || !fifo_empty;

    // Burst FSM driving the registered SRAM pins; any cycle without an access deselects the macro.
    always_ff @(posedge clk0 or posedge rst0) begin
        if (rst0) begin
            state    <= IDLE;
            cur_addr <= '0;
            beats    <= '0;
            csb0     <= 1'b1;
            web0     <= 1'b1;
            addr0    <= '0;
            din0     <= '0;
        end else begin
            csb0 <= 1'b1;
            web0 <= 1'b1;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        cur_addr <= cmd_addr;
                        beats    <= cmd_len;
                        state    <= cmd_write ? WRITE : READ;
                    end
                end
                WRITE: begin
                    if (wdata_valid) begin
                        csb0     <= 1'b0;
                        web0     <= 1'b0;
                        addr0    <= cur_addr;
                        din0     <= wdata;
                        cur_addr <= cur_addr + ADDR_WIDTH'(1);
                        beats    <= beats - ADDR_WIDTH'(1);
                        if (beats == '0) begin
                            state <= IDLE;
                        end
                    end
                end
                READ: begin
                    if (has_credit) begin
                        csb0     <= 1'b0;
                        addr0    <= cur_addr;
                        cur_addr <= cur_addr + ADDR_WIDTH'(1);
                        beats    <= beats - ADDR_WIDTH'(1);
                        if (beats == '0) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Two-stage "read issued" pipeline matching the SRAM capture edge plus the output settle edge.
    always_ff @(posedge clk0 or posedge rst0) begin
        if (rst0) begin
            rd_stage1 <= 1'b0;
            rd_stage2 <= 1'b0;
        end else begin
            rd_stage1 <= has_credit;
            rd_stage2 <= rd_stage1;
        end
    end

    sram_rsp_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk       (clk0),
        .rst       (rst0),
        .push      (rd_stage2),
        .push_data (dout0),
        .pop       (rdata_ready),
        .pop_data  (rdata),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_sram_burst_initiator.sv
// tb/tb_sram_burst_initiator.sv - self-checking bench for sram_burst_initiator with a behavioural SRAM
module tb_sram_burst_initiator;

    logic        clk0 = 1'b0;
    logic        rst0 = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [3:0]  cmd_addr = '0;
    logic [3:0]  cmd_len = '0;
    logic        wdata_valid = 1'b0;
    logic        wdata_ready;
    logic [15:0] wdata = '0;
    logic        rdata_valid;
    logic        rdata_ready = 1'b1;
    logic [15:0] rdata;
    logic        busy;
    logic        csb0;
    logic        web0;
    logic [3:0]  addr0;
    logic [15:0] din0;
    logic [15:0] dout0 = '0;

    logic [15:0] sram_mem [16];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int rd_issues = 0;
    int first_issue = -1;
    int first_valid = -1;
    logic [15:0] rx_q[$];
    int          rx_cyc[$];

    typedef struct {
        logic        wr;
        logic [3:0]  addr;
        logic [15:0] data;
        logic [15:0] exp;
    } vec_t;

    vec_t tbl [8];

    sram_burst_initiator dut (
        .clk0        (clk0),
        .rst0        (rst0),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_len     (cmd_len),
        .wdata_valid (wdata_valid),
        .wdata_ready (wdata_ready),
        .wdata       (wdata),
        .rdata_valid (rdata_valid),
        .rdata_ready (rdata_ready),
        .rdata       (rdata),
        .busy        (busy),
        .csb0        (csb0),
        .web0        (web0),
        .addr0       (addr0),
        .din0        (din0),
        .dout0       (dout0)
    );

    always #5 clk0 = ~clk0;

    initial begin
        for (int i = 0; i < 16; i++) sram_mem[i] = '0;
    end

    always @(posedge clk0) begin
        if (!csb0) begin
            if (!web0) sram_mem[addr0] <= din0;
            else       dout0 <= sram_mem[addr0];
        end
    end

    always @(posedge clk0) cyc <= cyc + 1;

    always @(negedge clk0) begin
        if (!rst0) begin
            if (!csb0 && web0) begin
                rd_issues = rd_issues + 1;
                if (first_issue < 0) first_issue = cyc;
            end
            if (rdata_valid && rdata_ready) begin
                rx_q.push_back(rdata);
                rx_cyc.push_back(cyc);
                if (first_valid < 0) first_valid = cyc;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic clear_mon();
        rx_q.delete();
        rx_cyc.delete();
        rd_issues   = 0;
        first_issue = -1;
        first_valid = -1;
    endtask

    // Called at a negedge; returns at the negedge following the accepting edge.
    task automatic issue_cmd(input logic w, input logic [3:0] a, input logic [3:0] l);
        int n = 0;
        while (!cmd_ready && n < 100) begin
            @(negedge clk0);
            n++;
        end
        check("cmd_ready_wait", {31'd0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_len   = l;
        @(negedge clk0);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rx(input int n);
        int k = 0;
        while (rx_q.size() < n && k < 200) begin
            @(negedge clk0);
            k++;
        end
        check("rx_count", rx_q.size(), n);
    endtask

    initial begin
        logic [3:0] ea [4];
        ea[0] = 4'd14; ea[1] = 4'd15; ea[2] = 4'd0; ea[3] = 4'd1;

        tbl[0] = '{1'b1, 4'd2, 16'h1111, 16'h0000};
        tbl[1] = '{1'b1, 4'd9, 16'h2222, 16'h0000};
        tbl[2] = '{1'b0, 4'd2, 16'h0000, 16'h1111};
        tbl[3] = '{1'b0, 4'd9, 16'h0000, 16'h2222};
        tbl[4] = '{1'b1, 4'd2, 16'h3333, 16'h0000};
        tbl[5] = '{1'b0, 4'd2, 16'h0000, 16'h3333};
        tbl[6] = '{1'b0, 4'd3, 16'h0000, 16'hB0B0};
        tbl[7] = '{1'b0, 4'd7, 16'h0000, 16'h0107};

        // Reset values
        repeat (3) @(posedge clk0);
        #1;
        check("rst_csb0", {31'd0, csb0}, 32'd1);
        check("rst_web0", {31'd0, web0}, 32'd1);
        check("rst_addr0", {28'd0, addr0}, 32'd0);
        check("rst_din0", {16'd0, din0}, 32'd0);
        check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("rst_wdata_ready", {31'd0, wdata_ready}, 32'd0);
        check("rst_rdata_valid", {31'd0, rdata_valid}, 32'd0);
        check("rst_rdata", {16'd0, rdata}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk0);
        rst0 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk0);
            check("idle_csb0", {31'd0, csb0}, 32'd1);
        end

        // Write burst wrapping the top of the address space
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'd14; cmd_len = 4'd3;
        @(posedge clk0); #1;
        check("wr_accept_ready", {31'd0, cmd_ready}, 32'd0);
        @(negedge clk0);
        cmd_valid = 1'b0; wdata_valid = 1'b1; wdata = 16'h00A0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk0); #1;
            check("wr_csb0", {31'd0, csb0}, 32'd0);
            check("wr_web0", {31'd0, web0}, 32'd0);
            check("wr_addr0", {28'd0, addr0}, {28'd0, ea[i]});
            check("wr_din0", {16'd0, din0}, 32'h00A0 + i);
            @(negedge clk0);
            wdata = 16'h00A1 + 16'(i);
        end
        wdata_valid = 1'b0;
        check("wr_done_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        @(posedge clk0); #1;
        check("wr_done_csb0", {31'd0, csb0}, 32'd1);
        @(negedge clk0);

        // Read burst, consumer always ready
        clear_mon();
        issue_cmd(1'b0, 4'd14, 4'd3);
        wait_rx(4);
        check("rd_latency", first_valid - first_issue, 32'd2);
        for (int i = 0; i < 4 && i < rx_q.size(); i++) begin
            check("rd_data", {16'd0, rx_q[i]}, 32'h00A0 + i);
            check("rd_consecutive", rx_cyc[i] - rx_cyc[0], i);
        end

        // Full-depth write then stalled 16-word read
        issue_cmd(1'b1, 4'd0, 4'd15);
        wdata_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            wdata = 16'h0100 + 16'(i);
            @(negedge clk0);
        end
        wdata_valid = 1'b0;
        rdata_ready = 1'b0;
        clear_mon();
        issue_cmd(1'b0, 4'd0, 4'd15);
        repeat (10) @(negedge clk0);
        check("stall_issues", rd_issues, 32'd4);
        check("stall_csb0", {31'd0, csb0}, 32'd1);
        check("stall_busy", {31'd0, busy}, 32'd1);
        check("stall_rdata_valid", {31'd0, rdata_valid}, 32'd1);
        rdata_ready = 1'b1;
        wait_rx(16);
        check("resume_issues", rd_issues, 32'd16);
        for (int i = 0; i < 16 && i < rx_q.size(); i++) begin
            check("resume_data", {16'd0, rx_q[i]}, 32'h0100 + i);
        end
        repeat (2) @(negedge clk0);
        check("resume_idle_busy", {31'd0, busy}, 32'd0);

        // Gapped write data, then immediate read-back
        clear_mon();
        issue_cmd(1'b1, 4'd3, 4'd1);
        wdata_valid = 1'b1; wdata = 16'hB0B0;
        @(posedge clk0); #1;
        check("gap_csb0_a", {31'd0, csb0}, 32'd0);
        check("gap_addr0_a", {28'd0, addr0}, 32'd3);
        @(negedge clk0);
        wdata_valid = 1'b0;
        check("gap_wdata_ready", {31'd0, wdata_ready}, 32'd1);
        @(posedge clk0); #1;
        check("gap_csb0_b", {31'd0, csb0}, 32'd1);
        check("gap_web0_b", {31'd0, web0}, 32'd1);
        @(negedge clk0);
        wdata_valid = 1'b1; wdata = 16'hB1B1;
        @(posedge clk0); #1;
        check("gap_csb0_c", {31'd0, csb0}, 32'd0);
        check("gap_din0_c", {16'd0, din0}, 32'hB1B1);
        @(negedge clk0);
        wdata = 16'hDEAD;
        check("idle_wdata_ready", {31'd0, wdata_ready}, 32'd0);
        issue_cmd(1'b0, 4'd4, 4'd0);
        check("idle_wdata_ignored", {31'd0, csb0}, 32'd1);
        wdata_valid = 1'b0;
        wait_rx(1);
        if (rx_q.size() > 0) check("raw_data", {16'd0, rx_q[0]}, 32'hB1B1);

        // Single-beat table
        for (int t = 0; t < 8; t++) begin
            if (tbl[t].wr) begin
                issue_cmd(1'b1, tbl[t].addr, 4'd0);
                wdata_valid = 1'b1;
                wdata = tbl[t].data;
                @(negedge clk0);
                wdata_valid = 1'b0;
            end else begin
                clear_mon();
                issue_cmd(1'b0, tbl[t].addr, 4'd0);
                wait_rx(1);
                if (rx_q.size() > 0) check("tbl_rdata", {16'd0, rx_q[0]}, {16'd0, tbl[t].exp});
            end
        end

        // Reset during a read with two reads in flight and one word buffered
        repeat (2) @(negedge clk0);
        rdata_ready = 1'b0;
        clear_mon();
        issue_cmd(1'b0, 4'd0, 4'd7);
        repeat (3) @(posedge clk0);
        #2;
        check("pre_rst_valid", {31'd0, rdata_valid}, 32'd1);
        rst0 = 1'b1;
        #1;
        check("mid_rst_rdata_valid", {31'd0, rdata_valid}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_csb0", {31'd0, csb0}, 32'd1);
        @(negedge clk0);
        rst0 = 1'b0;
        rdata_ready = 1'b1;
        @(negedge clk0);
        clear_mon();
        issue_cmd(1'b0, 4'd4, 4'd1);
        wait_rx(2);
        if (rx_q.size() > 1) begin
            check("post_rst_data0", {16'd0, rx_q[0]}, 32'hB1B1);
            check("post_rst_data1", {16'd0, rx_q[1]}, 32'h0105);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
